// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA scan counters, game-logic strobes and aligned sync/de/RGB output.
// Ports: clk, rst_n (sync, active low); sx/sy scan position; frame/line strobes;
//   red/green/blue_in colour returned PIPE_DLY cycles after sx/sy;
//   vga_hs/vga_vs/vga_de/vga_r/vga_g/vga_b registered VGA output.
// Optional: define VGA_TEST_PATTERN_EN to add pattern_sel (8 vertical colour bars).
module vga_timing_gen #(
  parameter int CORDW    = 10,
  parameter int H_RES    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_RES    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int PIPE_DLY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef VGA_TEST_PATTERN_EN
  input  logic             pattern_sel,
`endif
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             frame,
  output logic             line,
  input  logic [7:0]       red_in,
  input  logic [7:0]       green_in,
  input  logic [7:0]       blue_in,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_de,
  output logic [7:0]       vga_r,
  output logic [7:0]       vga_g,
  output logic [7:0]       vga_b
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_RES);
  localparam logic [CORDW-1:0] H_SS   = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] H_SE   = CORDW'(H_RES + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] V_SS   = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] V_SE   = CORDW'(V_RES + V_FP + V_SYNC);

  logic [CORDW-1:0] sx_n;
  logic [CORDW-1:0] sy_n;

  always_comb begin
    sx_n = sx + CORDW'(1);
    sy_n = sy;
    if (sx == H_LAST) begin
      sx_n = '0;
      sy_n = (sy == V_LAST) ? '0 : sy + CORDW'(1);
    end
  end

  logic de_raw;
  logic hs_raw;
  logic vs_raw;

  always_comb begin
    de_raw = (sx < H_ACT) && (sy < V_ACT);
    hs_raw = (sx >= H_SS && sx < H_SE) ? H_POL : ~H_POL;
    vs_raw = (sy >= V_SS && sy < V_SE) ? V_POL : ~V_POL;
  end

  // Strobes are registered, so they decode the position being loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sx    <= '0;
      sy    <= '0;
      frame <= 1'b0;
      line  <= 1'b0;
    end else begin
      sx    <= sx_n;
      sy    <= sy_n;
      frame <= (sx_n == '0) && (sy_n == V_ACT);
      line  <= (sx_n == '0);
    end
  end

  // Delay the decode by the game logic's colour latency.
  logic [PIPE_DLY-1:0] de_d;
  logic [PIPE_DLY-1:0] hs_d;
  logic [PIPE_DLY-1:0] vs_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      de_d <= '0;
      hs_d <= {PIPE_DLY{~H_POL}};
      vs_d <= {PIPE_DLY{~V_POL}};
    end else begin
      de_d[0] <= de_raw;
      hs_d[0] <= hs_raw;
      vs_d[0] <= vs_raw;
      for (int i = 1; i < PIPE_DLY; i++) begin
        de_d[i] <= de_d[i-1];
        hs_d[i] <= hs_d[i-1];
        vs_d[i] <= vs_d[i-1];
      end
    end
  end

  logic [7:0] r_sel;
  logic [7:0] g_sel;
  logic [7:0] b_sel;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_RES / 8;

  logic [CORDW-1:0] sx_d [PIPE_DLY];
  logic [2:0]       bar;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_DLY; i++) sx_d[i] <= '0;
    end else begin
      sx_d[0] <= sx;
      for (int i = 1; i < PIPE_DLY; i++) sx_d[i] <= sx_d[i-1];
    end
  end

  // Bars past the active width alias, but they are always blanked.
  assign bar = 3'(sx_d[PIPE_DLY-1] / CORDW'(BAR_W));

  // Bar order white..black maps to r=~bar[1], g=~bar[2], b=~bar[0].
  always_comb begin
    r_sel = red_in;
    g_sel = green_in;
    b_sel = blue_in;
    if (pattern_sel) begin
      r_sel = {8{~bar[1]}};
      g_sel = {8{~bar[2]}};
      b_sel = {8{~bar[0]}};
    end
  end
`else
  always_comb begin
    r_sel = red_in;
    g_sel = green_in;
    b_sel = blue_in;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_hs <= ~H_POL;
      vga_vs <= ~V_POL;
      vga_de <= 1'b0;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
    end else begin
      vga_hs <= hs_d[PIPE_DLY-1];
      vga_vs <= vs_d[PIPE_DLY-1];
      vga_de <= de_d[PIPE_DLY-1];
      vga_r  <= de_d[PIPE_DLY-1] ? r_sel : 8'h00;
      vga_g  <= de_d[PIPE_DLY-1] ? g_sel : 8'h00;
      vga_b  <= de_d[PIPE_DLY-1] ? b_sel : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: table vectors on a default 640x480 instance,
// scoreboard against a reduced-size instance for whole-frame behaviour.
module tb_vga_timing_gen;

  localparam int HR = 16, HF = 2, HS = 4, HB = 3;
  localparam int VR = 8, VF = 2, VS = 2, VB = 3;
  localparam int HT = HR + HF + HS + HB;
  localparam int VT = VR + VF + VS + VB;
  localparam int PD = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // default-parameter instance
  logic       rst_d = 1'b0;
  logic [7:0] rd = '0, gd = '0, bd = '0;
  logic [9:0] d_sx, d_sy;
  logic       d_fr, d_ln, d_hs, d_vs, d_de;
  logic [7:0] d_r, d_g, d_b;

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_d), .sx(d_sx), .sy(d_sy),
    .frame(d_fr), .line(d_ln),
    .red_in(rd), .green_in(gd), .blue_in(bd),
    .vga_hs(d_hs), .vga_vs(d_vs), .vga_de(d_de),
    .vga_r(d_r), .vga_g(d_g), .vga_b(d_b)
  );

  // reduced instance, hsync active high, deeper pipe
  logic       rst_s = 1'b0;
  logic [7:0] rs = '0, gs = '0, bs = '0;
  logic [9:0] s_sx, s_sy;
  logic       s_fr, s_ln, s_hs, s_vs, s_de;
  logic [7:0] s_r, s_g, s_b;

  vga_timing_gen #(
    .CORDW(10), .H_RES(HR), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_RES(VR), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b1), .V_POL(1'b0), .PIPE_DLY(PD)
  ) u_sm (
    .clk(clk), .rst_n(rst_s), .sx(s_sx), .sy(s_sy),
    .frame(s_fr), .line(s_ln),
    .red_in(rs), .green_in(gs), .blue_in(bs),
    .vga_hs(s_hs), .vga_vs(s_vs), .vga_de(s_de),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b)
  );

  typedef struct {
    int         sx;
    logic [7:0] r;
    logic       de;
    logic       hs;
    logic [7:0] er;
  } vec_t;

  typedef struct {
    logic de;
    logic hs;
    logic vs;
  } ent_t;

  ent_t       q[$];
  int         m_sx, m_sy;
  bit         m_rst;
  logic [7:0] pr, pg, pb;
  int         hs_run, vs_run, last_f, cyc;

  function automatic ent_t dec(input int x, input int y);
    ent_t e;
    e.de = (x < HR) && (y < VR);
    e.hs = (x >= HR + HF && x < HR + HF + HS);
    e.vs = !(y >= VR + VF && y < VR + VF + VS);
    return e;
  endfunction

  task automatic model_reset();
    ent_t z;
    z.de = 1'b0; z.hs = 1'b0; z.vs = 1'b1;
    m_sx = 0; m_sy = 0; m_rst = 1'b1;
    q.delete();
    for (int i = 0; i < PD + 1; i++) q.push_back(z);
    hs_run = 0; vs_run = 0; last_f = -1;
  endtask

  // Check one cycle of the reduced instance, then drive the next edge.
  task automatic step_s(input bit rst_v);
    ent_t e;
    @(negedge clk);
    chk("sx", s_sx, m_sx);
    chk("sy", s_sy, m_sy);
    chk("frame", s_fr, int'(!m_rst && m_sx == 0 && m_sy == VR));
    chk("line", s_ln, int'(!m_rst && m_sx == 0));
    q.push_back(dec(m_sx, m_sy));
    e = q.pop_front();
    chk("vga_de", s_de, e.de);
    chk("vga_hs", s_hs, e.hs);
    chk("vga_vs", s_vs, e.vs);
    chk("vga_r", s_r, e.de ? pr : 0);
    chk("vga_g", s_g, e.de ? pg : 0);
    chk("vga_b", s_b, e.de ? pb : 0);
    if (s_hs) hs_run++;
    else begin
      if (hs_run != 0) chk("hs_width", hs_run, HS);
      hs_run = 0;
    end
    if (!s_vs) vs_run++;
    else begin
      if (vs_run != 0) chk("vs_width", vs_run, VS * HT);
      vs_run = 0;
    end
    if (s_fr) begin
      if (last_f >= 0) chk("frame_period", cyc - last_f, HT * VT);
      last_f = cyc;
    end
    cyc++;
    pr = 8'($urandom); pg = 8'($urandom); pb = 8'($urandom);
    rs = pr; gs = pg; bs = pb;
    rst_s = rst_v;
    if (!rst_v) model_reset();
    else begin
      m_rst = 1'b0;
      if (m_sx == HT - 1) begin
        m_sx = 0;
        m_sy = (m_sy == VT - 1) ? 0 : m_sy + 1;
      end else m_sx++;
    end
  endtask

  vec_t tv[10];

  initial begin
    int k;
    tv[0] = '{0,   8'hFF, 1'b1, 1'b1, 8'hFF};
    tv[1] = '{1,   8'h5A, 1'b1, 1'b1, 8'h5A};
    tv[2] = '{639, 8'hA5, 1'b1, 1'b1, 8'hA5};
    tv[3] = '{640, 8'hFF, 1'b0, 1'b1, 8'h00};
    tv[4] = '{655, 8'hFF, 1'b0, 1'b1, 8'h00};
    tv[5] = '{656, 8'h33, 1'b0, 1'b0, 8'h00};
    tv[6] = '{700, 8'h44, 1'b0, 1'b0, 8'h00};
    tv[7] = '{751, 8'h55, 1'b0, 1'b0, 8'h00};
    tv[8] = '{752, 8'h66, 1'b0, 1'b1, 8'h00};
    tv[9] = '{799, 8'h77, 1'b0, 1'b1, 8'h00};

    for (int i = 0; i < 10; i++) begin
      @(negedge clk); rst_d = 1'b0;
      @(negedge clk); rst_d = 1'b1;
      if (i == 0) begin
        chk("rst_sx", d_sx, 0);
        chk("rst_sy", d_sy, 0);
        chk("rst_hs", d_hs, 1);
        chk("rst_vs", d_vs, 1);
        chk("rst_de", d_de, 0);
        chk("rst_r", d_r, 0);
        chk("rst_frame", d_fr, 0);
        chk("rst_line", d_ln, 0);
      end
      k = 0;
      while (d_sx != 10'(tv[i].sx) && k < 1000) begin
        @(negedge clk);
        k++;
      end
      if (k >= 1000) chk("tbl_timeout", 1, 0);
      repeat (2) @(negedge clk);
      rd = tv[i].r; gd = ~tv[i].r; bd = tv[i].r;
      @(negedge clk);
      chk("tbl_de", d_de, tv[i].de);
      chk("tbl_hs", d_hs, tv[i].hs);
      chk("tbl_vs", d_vs, 1);
      chk("tbl_r", d_r, tv[i].er);
      chk("tbl_g", d_g, tv[i].de ? 8'(~tv[i].r) : 0);
      chk("tbl_b", d_b, tv[i].de ? tv[i].r : 0);
      rd = '0; gd = '0; bd = '0;
    end

    cyc = 0;
    pr = '0; pg = '0; pb = '0;
    model_reset();
    step_s(1'b0);
    for (int i = 0; i < 3 * HT * VT + 10; i++) step_s(1'b1);

    k = 0;
    while (!(m_sx == 10 && m_sy == 5) && k < 2 * HT * VT) begin
      step_s(1'b1);
      k++;
    end
    if (k >= 2 * HT * VT) chk("mid_timeout", 1, 0);
    step_s(1'b0);
    for (int i = 0; i < 2 * HT * VT + 10; i++) step_s(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
